// File: rtl/skip_block_subtractor.sv
// Multi-cycle borrow-skip subtractor: diff = a - b - borrow_in, one BLOCK-bit slice per clock, LSB first.
// Optional signed-overflow output `ovf` is present only when SKIP_SUB_OVF_EN is defined.
module skip_block_subtractor #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  localparam int NB = WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SKIP_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [NB-1:0]    skip_mask
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; start is accepted only in IDLE, the result is released only in DONE.
  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow;
  logic [IW-1:0]    idx;

  logic [BLOCK-1:0] a_s;
  logic [BLOCK-1:0] b_s;
  logic [BLOCK-1:0] slice_d;
  logic             slice_bo;
  logic             last_slice;

  assign start_ready = (state == S_IDLE);
  assign last_slice  = (idx == IW'(NB - 1));

  always_comb begin
    a_s = a_r[idx*BLOCK +: BLOCK];
    b_s = b_r[idx*BLOCK +: BLOCK];
    {slice_bo, slice_d} = {1'b0, a_s} - {1'b0, b_s} - {{BLOCK{1'b0}}, borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_r        <= '0;
      b_r        <= '0;
      borrow     <= 1'b0;
      idx        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      skip_mask  <= '0;
      done_valid <= 1'b0;
`ifdef SKIP_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_r       <= a;
            b_r       <= b;
            borrow    <= borrow_in;
            idx       <= '0;
            diff      <= '0;
            skip_mask <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          diff[idx*BLOCK +: BLOCK] <= slice_d;
          // A slice whose bits all match passes the incoming borrow straight through.
          skip_mask[idx] <= &(~(a_s ^ b_s));
          borrow         <= slice_bo;
          if (last_slice) begin
            borrow_out <= slice_bo;
`ifdef SKIP_SUB_OVF_EN
            ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (slice_d[BLOCK-1] != a_r[WIDTH-1]);
`endif
            done_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          done_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
